// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, frame FSM encoding and key-level bundle for the
// PS/2 keyboard front end.
package keyboard_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_FIRE  = 8'h29;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    typedef struct packed {
        logic right;
        logic left;
        logic fire;
    } key_levels_t;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host byte receiver: pin synchronisers, falling-edge detect,
// frame FSM with mid-frame timeout, and one-cycle byteValid/frameErr pulses.
module ps2_byte_rx
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       frameErr
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // [0],[1] form the synchroniser; [2] is the previous synchronised value.
    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    logic fall;
    logic data;
    logic timeout;

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign data    = dat_sync_q[1];
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_comb begin
        clk_sync_d   = {clk_sync_q[1:0], ps2Clk};
        dat_sync_d   = {dat_sync_q[0], ps2Data};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        to_cnt_d     = to_cnt_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (fall)
            to_cnt_d = '0;
        else if (state_q != IDLE)
            to_cnt_d = to_cnt_q + TW'(1);

        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Parity and stop faults collapse into one error pulse.
                    if (data && odd_parity_ok(shift_q, par_q)) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchronisers reset to the idle-high line level so release never fakes an edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_q   <= 3'b111;
            dat_sync_q   <= 2'b11;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byteValid = byte_valid_q;
    assign rxByte    = rx_byte_q;
    assign frameErr  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Keyboard front end: turns received PS/2 make/break sequences into held-key
// levels for right arrow, left arrow and space.
module ps2_key_decoder
    import keyboard_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] RIGHT_CODE     = KEY_RIGHT,
    parameter logic [7:0] LEFT_CODE      = KEY_LEFT,
    parameter logic [7:0] FIRE_CODE      = KEY_FIRE
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       right,
    output logic       left,
    output logic       fire,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       frameErr
);

    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_err;

    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    key_levels_t keys_q, keys_d;

    ps2_byte_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .resetN   (resetN),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .byteValid(rx_valid),
        .rxByte   (rx_byte),
        .frameErr (rx_err)
    );

    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        keys_d = keys_q;

        // A damaged frame may have been part of a break sequence; forget any prefix.
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q && rx_byte == RIGHT_CODE)
                    keys_d.right = ~brk_q;
                if (ext_q && rx_byte == LEFT_CODE)
                    keys_d.left = ~brk_q;
                if (!ext_q && rx_byte == FIRE_CODE)
                    keys_d.fire = ~brk_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            keys_q <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            keys_q <= keys_d;
        end
    end

    assign right     = keys_q.right;
    assign left      = keys_q.left;
    assign fire      = keys_q.fire;
    assign byteValid = rx_valid;
    assign rxByte    = rx_byte;
    assign frameErr  = rx_err;

endmodule
